// File: rtl/instr_wb_slave_pipe.sv
// ============================================================================
// Module   : instr_wb_slave_pipe
// Brief    : Instrumented Wishbone B4 pipelined slave with in-order responses,
//            programmable latency and bench-driven stall/hold/err/data injection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_wb_slave_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [ADDR_WIDTH-1:0]       wb_adr_i,
    input  logic [DATA_WIDTH-1:0]       wb_dat_i,
    input  logic                        wb_we_i,
    input  logic [DATA_WIDTH/8-1:0]     wb_sel_i,
    input  logic                        wb_stb_i,
    input  logic                        wb_cyc_i,
    output logic [DATA_WIDTH-1:0]       wb_dat_o,
    output logic                        wb_ack_o,
    output logic                        wb_err_o,
    output logic                        wb_stall_o,
    input  logic                        stall_request_i,
    input  logic                        ack_hold_i,
    input  logic                        err_request_i,
    input  logic [DATA_WIDTH-1:0]       injected_data_i,
    output logic                        wr_valid_o,
    output logic [ADDR_WIDTH-1:0]       wr_adr_o,
    output logic [DATA_WIDTH-1:0]       wr_dat_o,
    output logic [DATA_WIDTH/8-1:0]     wr_sel_o,
    output logic [$clog2(DEPTH+1)-1:0]  pending_o,
    output logic [31:0]                 req_count_o
);

    localparam int SEL_W  = DATA_WIDTH / 8;
    localparam int PEND_W = $clog2(DEPTH + 1);
    localparam int AGE_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic                  r_we  [DEPTH];
    logic [AGE_W-1:0]      r_age [DEPTH];
    logic [PEND_W-1:0]     r_pending;
    logic [31:0]           r_req_count;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_wr_valid;
    logic [ADDR_WIDTH-1:0] r_wr_adr;
    logic [DATA_WIDTH-1:0] r_wr_dat;
    logic [SEL_W-1:0]      r_wr_sel;

    logic                  w_up_we  [DEPTH];
    logic [AGE_W-1:0]      w_up_age [DEPTH];
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [PEND_W-1:0]     w_slot;

    function automatic logic [AGE_W-1:0] age_dec(input logic [AGE_W-1:0] a);
        return (a != '0) ? a - AGE_W'(1) : a;
    endfunction

    // Entry that slides into each slot when the head retires.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_up
        if (gi < DEPTH - 1) begin : g_mid
            assign w_up_we[gi]  = r_we[gi+1];
            assign w_up_age[gi] = r_age[gi+1];
        end else begin : g_top
            assign w_up_we[gi]  = r_we[gi];
            assign w_up_age[gi] = r_age[gi];
        end
    end

    assign w_full     = (r_pending == PEND_W'(DEPTH));
    assign wb_stall_o = stall_request_i | w_full;
    assign w_push     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign w_pop      = wb_cyc_i & (r_pending != '0) & (r_age[0] == '0) & ~ack_hold_i;
    assign w_slot     = r_pending - PEND_W'(w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_we[i]  <= 1'b0;
                r_age[i] <= '0;
            end
            r_pending   <= '0;
            r_req_count <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_dat       <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_adr    <= '0;
            r_wr_dat    <= '0;
            r_wr_sel    <= '0;
        end else begin
            r_wr_valid <= w_push & wb_we_i;
            if (w_push && wb_we_i) begin
                r_wr_adr <= wb_adr_i;
                r_wr_dat <= wb_dat_i;
                r_wr_sel <= wb_sel_i;
            end
            if (w_push) begin
                r_req_count <= r_req_count + 32'd1;
            end

            r_ack <= w_pop & ~err_request_i;
            r_err <= w_pop & err_request_i;
            r_dat <= (w_pop && !err_request_i && !r_we[0]) ? injected_data_i : '0;

            if (!wb_cyc_i) begin
                r_pending <= '0;
            end else if (w_push && !w_pop) begin
                r_pending <= r_pending + PEND_W'(1);
            end else if (w_pop && !w_push) begin
                r_pending <= r_pending - PEND_W'(1);
            end

            // Stale slots beyond r_pending age harmlessly; a push overwrites them.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (w_slot == PEND_W'(i))) begin
                    r_we[i]  <= wb_we_i;
                    r_age[i] <= AGE_W'(LATENCY - 1);
                end else begin
                    r_we[i]  <= w_pop ? w_up_we[i] : r_we[i];
                    r_age[i] <= age_dec(w_pop ? w_up_age[i] : r_age[i]);
                end
            end
        end
    end

    assign wb_ack_o    = r_ack;
    assign wb_err_o    = r_err;
    assign wb_dat_o    = r_dat;
    assign wr_valid_o  = r_wr_valid;
    assign wr_adr_o    = r_wr_adr;
    assign wr_dat_o    = r_wr_dat;
    assign wr_sel_o    = r_wr_sel;
    assign pending_o   = r_pending;
    assign req_count_o = r_req_count;

endmodule

`default_nettype wire
